// File: rtl/edge_io_cfg_if.sv
// Scan-configuration port bundle for edge_io_cfg: serial chain control plus
// configuration status. The scan driver is the master; the I/O boundary is the slave.
interface edge_io_cfg_if;
  logic conn_scan_en;
  logic conn_scan_in;
  logic conn_scan_out;
  logic conn_scan_update;
  logic cfg_valid;
  logic cfg_err;

  modport master (
    output conn_scan_en, conn_scan_in, conn_scan_update,
    input  conn_scan_out, cfg_valid, cfg_err
  );

  modport slave (
    input  conn_scan_en, conn_scan_in, conn_scan_update,
    output conn_scan_out, cfg_valid, cfg_err
  );
endinterface

// File: rtl/edge_io_cfg.sv
// Scan-configured fabric-edge I/O boundary: shadow shift register, length-checked
// commit into the live per-cell config, and per-pin input/output data paths.
module edge_io_cfg #(
  parameter int unsigned NUM_IO    = 10,
  parameter int unsigned CFG_BITS  = 4,
  parameter int unsigned CHAIN_LEN = NUM_IO * CFG_BITS
) (
  input  logic              scan_clk,
  input  logic              rst,
  edge_io_cfg_if.slave      scan,
  input  logic [NUM_IO-1:0] fpga_in,
  output logic [NUM_IO-1:0] fpga_out,
  output logic [NUM_IO-1:0] pad_oe,
  input  logic [NUM_IO-1:0] clb_out,
  output logic [NUM_IO-1:0] clb_in
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] sr_q, sr_d;
  logic [CHAIN_LEN-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [NUM_IO-1:0]    in_q, in_d;
  logic [NUM_IO-1:0]    out_q, out_d;

  logic [NUM_IO-1:0] in_reg, out_reg, out_en, inv;
  logic [NUM_IO-1:0] d_in, q_out;
  logic              do_shift, do_update, len_ok;

  always_comb begin
    in_reg  = '0;
    out_reg = '0;
    out_en  = '0;
    inv     = '0;
    for (int unsigned i = 0; i < NUM_IO; i++) begin
      in_reg[i]  = cfg_q[CFG_BITS*i + 0];
      out_reg[i] = cfg_q[CFG_BITS*i + 1];
      out_en[i]  = cfg_q[CFG_BITS*i + 2];
      inv[i]     = cfg_q[CFG_BITS*i + 3];
    end
  end

  assign d_in  = fpga_in ^ inv;
  assign q_out = clb_out ^ inv;

  // Shift wins over update when both are asserted; the counter keeps its value.
  assign do_shift  = scan.conn_scan_en;
  assign do_update = scan.conn_scan_update & ~scan.conn_scan_en;
  assign len_ok    = (cnt_q == CNT_FULL);

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    valid_d = valid_q;
    err_d   = err_q;
    in_d    = d_in;
    out_d   = q_out;
    if (do_shift) begin
      sr_d = {sr_q[CHAIN_LEN-2:0], scan.conn_scan_in};
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
    end
    if (do_update) begin
      cnt_d = '0;
      if (len_ok) begin
        cfg_d   = sr_q;
        valid_d = 1'b1;
        err_d   = 1'b0;
      end else begin
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge scan_clk or posedge rst) begin
    if (rst) begin
      sr_q    <= '0;
      cfg_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      in_q    <= '0;
      out_q   <= '0;
    end else begin
      sr_q    <= sr_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      in_q    <= in_d;
      out_q   <= out_d;
    end
  end

  assign pad_oe   = out_en & {NUM_IO{valid_q}};
  assign fpga_out = ((out_reg & out_q) | (~out_reg & q_out)) & pad_oe;
  assign clb_in   = valid_q ? ((in_reg & in_q) | (~in_reg & d_in)) : '0;

  assign scan.conn_scan_out = sr_q[CHAIN_LEN-1];
  assign scan.cfg_valid     = valid_q;
  assign scan.cfg_err       = err_q;

endmodule

// File: tb/tb_edge_io_cfg.sv
// Directed bench for edge_io_cfg: scan load/commit rules, data-path modes,
// shift isolation and asynchronous reset.
module tb_edge_io_cfg;
  logic       scan_clk = 1'b0;
  logic       rst;
  logic [9:0] fpga_in, clb_out;
  logic [9:0] fpga_out, pad_oe, clb_in;

  edge_io_cfg_if sif ();

  edge_io_cfg #(.NUM_IO(10), .CFG_BITS(4)) dut (
    .scan_clk (scan_clk),
    .rst      (rst),
    .scan     (sif.slave),
    .fpga_in  (fpga_in),
    .fpga_out (fpga_out),
    .pad_oe   (pad_oe),
    .clb_out  (clb_out),
    .clb_in   (clb_in)
  );

  always #5 scan_clk = ~scan_clk;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [39:0] CFG_A = 40'h00_0000_0004; // cell0 out_en
  localparam logic [39:0] CFG_B = 40'h00_0060_9000; // cell3 inv+in_reg, cell5 out_reg+out_en
  localparam logic [39:0] CFG_C = 40'h00_0020_9000; // as B, cell5 out_en cleared
  localparam logic [39:0] CFG_D = 40'h80_0060_9000; // as B, cell9 inv (MSB set)

  typedef struct {
    logic [9:0] fin;
    logic [9:0] cout;
    logic [9:0] exp_cin;
    logic [9:0] exp_fout;
    logic [9:0] exp_oe;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge scan_clk);
    #1;
  endtask

  // Shifts n bits; bit k of w (mod 40) goes in, highest index first.
  task automatic shift_n(input int n, input logic [39:0] w);
    for (int k = n - 1; k >= 0; k--) begin
      sif.conn_scan_en = 1'b1;
      sif.conn_scan_in = w[k % 40];
      tick();
    end
    sif.conn_scan_en = 1'b0;
    sif.conn_scan_in = 1'b0;
  endtask

  task automatic do_update();
    sif.conn_scan_update = 1'b1;
    tick();
    sif.conn_scan_update = 1'b0;
    #1;
  endtask

  logic [3:0] seq_in    = 4'b0110;  // applied bit0 first: 0,1,1,0
  logic [3:0] seq_pre   = 4'b0011;  // clb_in[3] before each edge: 1,1,0,0
  logic [3:0] seq_post  = 4'b1001;  // clb_in[3] after each edge:  1,0,0,1

  initial begin
    vt[0] = '{fin: 10'h000, cout: 10'h000, exp_cin: 10'h000, exp_fout: 10'h000, exp_oe: 10'h001};
    vt[1] = '{fin: 10'h3FF, cout: 10'h3FF, exp_cin: 10'h3FF, exp_fout: 10'h001, exp_oe: 10'h001};
    vt[2] = '{fin: 10'h2AA, cout: 10'h155, exp_cin: 10'h2AA, exp_fout: 10'h001, exp_oe: 10'h001};
    vt[3] = '{fin: 10'h155, cout: 10'h2AA, exp_cin: 10'h155, exp_fout: 10'h000, exp_oe: 10'h001};
    vt[4] = '{fin: 10'h0F0, cout: 10'h3FE, exp_cin: 10'h0F0, exp_fout: 10'h000, exp_oe: 10'h001};

    rst = 1'b1;
    sif.conn_scan_en = 1'b0;
    sif.conn_scan_in = 1'b0;
    sif.conn_scan_update = 1'b0;
    fpga_in = 10'h3FF;
    clb_out = 10'h3FF;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("rst_scan_out", sif.conn_scan_out, 0);
    chk("rst_valid", sif.cfg_valid, 0);
    chk("rst_err", sif.cfg_err, 0);
    chk("rst_fpga_out", fpga_out, 0);
    chk("rst_pad_oe", pad_oe, 0);
    chk("rst_clb_in_forced", clb_in, 0);

    shift_n(40, CFG_A);
    chk("a_shadow_not_live", pad_oe, 0);
    do_update();
    chk("a_valid", sif.cfg_valid, 1);
    chk("a_err", sif.cfg_err, 0);
    chk("a_pad_oe", pad_oe, 10'h001);

    for (int v = 0; v < 5; v++) begin
      fpga_in = vt[v].fin;
      clb_out = vt[v].cout;
      #1;
      chk($sformatf("vec%0d_clb_in", v), clb_in, vt[v].exp_cin);
      chk($sformatf("vec%0d_fpga_out", v), fpga_out, vt[v].exp_fout);
      chk($sformatf("vec%0d_pad_oe", v), pad_oe, vt[v].exp_oe);
    end

    fpga_in = 10'h2AA;
    clb_out = 10'h001;
    shift_n(39, 40'h0);
    do_update();
    chk("short_err", sif.cfg_err, 1);
    chk("short_valid", sif.cfg_valid, 1);
    chk("short_pad_oe", pad_oe, 10'h001);
    chk("short_fpga_out", fpga_out, 10'h001);
    chk("short_clb_in", clb_in, 10'h2AA);

    shift_n(40, CFG_B);
    do_update();
    chk("b_err", sif.cfg_err, 0);
    chk("b_pad_oe", pad_oe, 10'h020);

    // cell3: inverted, registered input
    fpga_in = 10'h000;
    tick();
    for (int j = 0; j < 4; j++) begin
      fpga_in[3] = seq_in[j];
      #1;
      chk($sformatf("c3_pre%0d", j), clb_in[3], seq_pre[j]);
      tick();
      chk($sformatf("c3_post%0d", j), clb_in[3], seq_post[j]);
    end

    // cell5: registered output, one-cycle pulse
    clb_out = 10'h000;
    tick();
    clb_out[5] = 1'b1;
    #1;
    chk("c5_same_cycle", fpga_out[5], 0);
    tick();
    chk("c5_delayed_hi", fpga_out[5], 1);
    clb_out[5] = 1'b0;
    #1;
    chk("c5_hold", fpga_out[5], 1);
    tick();
    chk("c5_delayed_lo", fpga_out[5], 0);

    shift_n(81, CFG_C);
    do_update();
    chk("long_err", sif.cfg_err, 1);
    chk("long_pad_oe", pad_oe, 10'h020);

    shift_n(40, CFG_C);
    do_update();
    chk("c_err", sif.cfg_err, 0);
    chk("c_pad_oe", pad_oe, 10'h000);
    clb_out = 10'h3FF;
    tick();
    tick();
    chk("c_fpga_out5_off", fpga_out[5], 0);

    // Update asserted together with the final shift edge is ignored.
    for (int k = 39; k >= 1; k--) begin
      sif.conn_scan_en = 1'b1;
      sif.conn_scan_in = CFG_A[k];
      tick();
    end
    sif.conn_scan_in = CFG_A[0];
    sif.conn_scan_update = 1'b1;
    tick();
    sif.conn_scan_en = 1'b0;
    chk("both_cfg_kept", pad_oe, 10'h000);
    chk("both_err", sif.cfg_err, 0);
    tick();
    sif.conn_scan_update = 1'b0;
    #1;
    chk("after_both_pad_oe", pad_oe, 10'h001);
    chk("after_both_err", sif.cfg_err, 0);

    // Live config A must not move while a new pattern shifts through.
    fpga_in = 10'h155;
    clb_out = 10'h0AB;
    #1;
    for (int k = 39; k >= 0; k--) begin
      sif.conn_scan_en = 1'b1;
      sif.conn_scan_in = CFG_D[k];
      tick();
      chk("iso_clb_in", clb_in, 10'h155);
      chk("iso_fpga_out", fpga_out, 10'h001);
      chk("iso_pad_oe", pad_oe, 10'h001);
      if (k == 1) chk("lat_before", sif.conn_scan_out, 0);
    end
    sif.conn_scan_en = 1'b0;
    chk("lat_at_40", sif.conn_scan_out, 1);

    // Asynchronous reset mid-shift, away from any clock edge.
    shift_n(20, CFG_D);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_clb_in", clb_in, 0);
    chk("arst_fpga_out", fpga_out, 0);
    chk("arst_pad_oe", pad_oe, 0);
    chk("arst_valid", sif.cfg_valid, 0);
    chk("arst_scan_out", sif.conn_scan_out, 0);
    tick();
    rst = 1'b0;
    tick();
    do_update();
    chk("post_rst_err", sif.cfg_err, 1);
    chk("post_rst_valid", sif.cfg_valid, 0);
    chk("post_rst_pad_oe", pad_oe, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/edge_io_cfg.md
# edge_io_cfg

Parametrised, scan-configured I/O boundary for the fabric edge. It sits between chip pads (`fpga_in`/`fpga_out`) and the edge routing/CLB pins, with one I/O cell per pin. Each cell has configurable input and output registers, output enable and polarity. Configuration shifts in over the existing `conn_scan_*` chain into a shadow register. A length-checked update pulse commits it, so shifting never disturbs live configuration.

## Interface
Parameters:
- `NUM_IO`, 10, number of I/O cells
- `CFG_BITS`, 4, config bits per cell (fixed at 4; parameter for chain-length arithmetic only)
- `CHAIN_LEN`, `NUM_IO*CFG_BITS`, derived shadow-register length

Ports:
- `scan_clk`  input  1  sole clock; all state on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `conn_scan_en`  input  1  shift enable
- `conn_scan_in`  input  1  serial config in
- `conn_scan_out`  output  1  serial config out (shadow MSB)
- `conn_scan_update`  input  1  commit shadow to active config
- `fpga_in`  input  NUM_IO  pad-side input
- `fpga_out`  output  NUM_IO  pad-side output data
- `pad_oe`  output  NUM_IO  pad output enable
- `clb_out`  input  NUM_IO  fabric-side data toward pads
- `clb_in`  output  NUM_IO  fabric-side data from pads
- `cfg_valid`  output  1  at least one update accepted since reset
- `cfg_err`  output  1  sticky: last update rejected

## Operation
- Cell i active config `CFG[4i+3:4i]`:
  - bit0 `in_reg`
  - bit1 `out_reg`
  - bit2 `out_en`
  - bit3 `inv`
- Shift (`conn_scan_en`=1): `SR[0]<=conn_scan_in`, `SR[k]<=SR[k-1]`. `conn_scan_out=SR[CHAIN_LEN-1]`. The first bit shifted in ends at cell NUM_IO-1 bit3.
- Shift counter `cnt`:
  - increments per shift edge
  - saturates at CHAIN_LEN+1
  - cleared on any update attempt
- Update (`conn_scan_update`=1 and `conn_scan_en`=0):
  - If `cnt==CHAIN_LEN`: `CFG<=SR`, `cfg_valid<=1`, `cfg_err<=0`.
  - Else: CFG unchanged, `cfg_err<=1`.
- `conn_scan_update` with `conn_scan_en`=1: the shift occurs, the update is ignored, and `cnt` is not cleared.
- Input path: `d=fpga_in[i]^inv`.
  - `in_reg`=1: `clb_in[i]` is `d` registered.
  - `in_reg`=0: combinational.
- Output path: `q=clb_out[i]^inv`, registered if `out_reg`=1, else combinational.
  - `fpga_out[i]=q & out_en & cfg_valid`
  - `pad_oe[i]=out_en & cfg_valid`
- While `cfg_valid`=0, `clb_in` is forced to 0.
- Data registers load every cycle regardless of mode, so switching to registered mode shows the prior cycle's value.

## Timing
- Reset values:
  - `SR`, `CFG`, `cnt`, data registers = 0
  - `cfg_valid`=0, `cfg_err`=0
  - consequently `conn_scan_out`=0, `fpga_out`=0, `pad_oe`=0, `clb_in`=0
- Reset is asynchronous: outputs go to reset values immediately on `rst` assertion, independent of `scan_clk`.
- Reset mid-shift discards partial shadow contents and `cnt`. A subsequent update requires a full CHAIN_LEN shift.
- Shift latency: a bit entering at edge n appears on `conn_scan_out` after edge n+CHAIN_LEN-1.
- Update takes effect at the committing edge. Combinational paths reflect the new CFG immediately after it; registered paths after one further edge.
- Registered in/out paths: exactly 1-cycle latency. Combinational paths: 0 cycles.
- Shadow shifting never alters CFG, `clb_in`, `fpga_out` or `pad_oe`.
- `cnt` saturation: any shift count ≥ CHAIN_LEN+1 is rejected on update (no wrap-around acceptance at 2·CHAIN_LEN).

## Test plan
- Reset, then shift 40 bits loading cell0=4'b0100 and all others 0, then pulse update → `cfg_valid`=1, `cfg_err`=0, `pad_oe`=10'b0000000001. `fpga_out[0]` tracks `clb_out[0]` same cycle; `clb_in[9:1]` track `fpga_in[9:1]` combinationally.
- Shift 39 bits, then update → `cfg_err`=1, CFG and all outputs unchanged. Shift 40 bits, then update → `cfg_err`=0, new CFG live. Shift 81 bits, then update → rejected.
- Cell3 = 4'b1001 (`inv`, `in_reg`); drive `fpga_in[3]` 0,1,1,0 on successive cycles → `clb_in[3]` reads 1,1,0,0,1 starting the cycle after the first drive.
- Cell5 = 4'b0110 (`out_reg`, `out_en`); `clb_out[5]` pulses 1 for one cycle → `fpga_out[5]` high exactly one cycle later for one cycle. Set `out_en`=0 → `fpga_out[5]`=0, `pad_oe[5]`=0.
- Assert `conn_scan_en` and `conn_scan_update` together on the 40th shift edge → shift happens, CFG unchanged. Deassert `en` and update next cycle → accepted (`cnt`=40).
- With live config, shift a new pattern while checking all fabric/pad outputs stay constant. Assert `rst` after 20 shifts → all outputs 0 asynchronously; post-reset update without shifting → `cfg_err`=1.
